// File: rtl/adpll_acq_controller.sv
// adpll_acq_controller: SAR bias search, lock qualification and re-acquisition for the ring-oscillator ADPLL.
// Ports: fpga_clk_i/reset_i (sync, active-high); enable_i run level; error_i/error_valid_i phase-error samples;
//        bias_o oscillator bias; loop_reset_o loop filter reset; locked_o; fail_o; state_o (IDLE..FAIL = 0..4).
module adpll_acq_controller #(
  parameter int RO_WIDTH       = 5,
  parameter int PDET_WIDTH     = 8,
  parameter int SETTLE_SAMPLES = 4,
  parameter int LOCK_TOL       = 2,
  parameter int LOCK_COUNT     = 16,
  parameter int UNLOCK_TOL     = 8,
  parameter int UNLOCK_COUNT   = 4,
  parameter int TRACK_TIMEOUT  = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [PDET_WIDTH-1:0] error_i,
  input  logic                  error_valid_i,
  output logic [RO_WIDTH-1:0]   bias_o,
  output logic                  loop_reset_o,
  output logic                  locked_o,
  output logic                  fail_o,
  output logic [2:0]            state_o
);
  function automatic int cw(input int n);
    return n < 1 ? 1 : $clog2(n + 1);
  endfunction
  localparam int KW = cw(RO_WIDTH - 1);
  localparam int SW = cw(SETTLE_SAMPLES);
  localparam int LW = cw(LOCK_COUNT);
  localparam int UW = cw(UNLOCK_COUNT);
  localparam int TW = cw(TRACK_TIMEOUT);
  localparam int RW = cw(MAX_RETRIES);
  localparam logic [RO_WIDTH-1:0]   BIAS_MID = {1'b1, {(RO_WIDTH-1){1'b0}}};
  localparam logic [KW-1:0]         K_MSB    = KW'(RO_WIDTH - 1);
  localparam logic [PDET_WIDTH-1:0] ERR_MIN  = {1'b1, {(PDET_WIDTH-1){1'b0}}};
  localparam logic [PDET_WIDTH-1:0] ERR_MAX  = {1'b0, {(PDET_WIDTH-1){1'b1}}};
  localparam logic [PDET_WIDTH-1:0] LTOL     = PDET_WIDTH'(LOCK_TOL);
  localparam logic [PDET_WIDTH-1:0] UTOL     = PDET_WIDTH'(UNLOCK_TOL);
  typedef enum logic [2:0] {S_IDLE, S_SWEEP, S_TRACK, S_LOCKED, S_FAIL} state_e;
  state_e                state_q, state_d;
  logic [RO_WIDTH-1:0]   bias_q, bias_d;
  logic [KW-1:0]         k_q, k_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [LW-1:0]         lock_q, lock_d;
  logic [UW-1:0]         unlock_q, unlock_d;
  logic [TW-1:0]         timeout_q, timeout_d;
  logic [RW-1:0]         retry_q, retry_d;
  logic [PDET_WIDTH-1:0] mag;
  logic                  err_pos, in_lock, out_lock;
  // The most negative code has no positive twin, so it saturates to the largest magnitude.
  assign mag      = !error_i[PDET_WIDTH-1] ? error_i : (error_i == ERR_MIN ? ERR_MAX : -error_i);
  assign err_pos  = !error_i[PDET_WIDTH-1] && |error_i;
  assign in_lock  = mag <= LTOL;
  assign out_lock = mag > UTOL;
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      bias_q    <= BIAS_MID;
      k_q       <= K_MSB;
      settle_q  <= '0;
      lock_q    <= '0;
      unlock_q  <= '0;
      timeout_q <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      bias_q    <= bias_d;
      k_q       <= k_d;
      settle_q  <= settle_d;
      lock_q    <= lock_d;
      unlock_q  <= unlock_d;
      timeout_q <= timeout_d;
      retry_q   <= retry_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    bias_d    = bias_q;
    k_d       = k_q;
    settle_d  = settle_q;
    lock_d    = lock_q;
    unlock_d  = unlock_q;
    timeout_d = timeout_q;
    retry_d   = retry_q;
    if (!enable_i) begin
      state_d   = S_IDLE;
      bias_d    = BIAS_MID;
      k_d       = K_MSB;
      settle_d  = '0;
      lock_d    = '0;
      unlock_d  = '0;
      timeout_d = '0;
      retry_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_SWEEP;
          bias_d   = BIAS_MID;
          k_d      = K_MSB;
          settle_d = '0;
          retry_d  = '0;
        end
        S_SWEEP: if (error_valid_i) begin
          if (settle_q != SW'(SETTLE_SAMPLES)) settle_d = settle_q + 1'b1;
          else begin
            bias_d[k_q] = err_pos;
            if (k_q != '0) begin
              bias_d[k_q - 1'b1] = 1'b1;
              k_d                = k_q - 1'b1;
              settle_d           = '0;
            end else begin
              state_d   = S_TRACK;
              lock_d    = '0;
              timeout_d = '0;
            end
          end
        end
        S_TRACK: if (error_valid_i) begin
          timeout_d = timeout_q + 1'b1;
          lock_d    = in_lock ? lock_q + 1'b1 : '0;
          if (lock_d == LW'(LOCK_COUNT)) begin
            state_d  = S_LOCKED;
            unlock_d = '0;
          end else if (timeout_d == TW'(TRACK_TIMEOUT)) begin
            if (retry_q != RW'(MAX_RETRIES)) begin
              state_d  = S_SWEEP;
              retry_d  = retry_q + 1'b1;
              bias_d   = BIAS_MID;
              k_d      = K_MSB;
              settle_d = '0;
            end else state_d = S_FAIL;
          end
        end
        S_LOCKED: if (error_valid_i) begin
          // Samples inside the hysteresis band count as "not out of lock" and clear the run.
          unlock_d = out_lock ? unlock_q + 1'b1 : '0;
          if (unlock_d == UW'(UNLOCK_COUNT)) begin
            state_d  = S_SWEEP;
            retry_d  = '0;
            bias_d   = BIAS_MID;
            k_d      = K_MSB;
            settle_d = '0;
          end
        end
        S_FAIL: state_d = S_FAIL;
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_comb begin
    bias_o       = bias_q;
    loop_reset_o = !(state_q == S_TRACK || state_q == S_LOCKED);
    locked_o     = state_q == S_LOCKED;
    fail_o       = state_q == S_FAIL;
    state_o      = state_q;
  end
endmodule

// File: tb/tb_adpll_acq_controller.sv
// tb_adpll_acq_controller: directed self-checking bench for adpll_acq_controller.
module tb_adpll_acq_controller;
  logic       clk = 1'b0;
  logic       rst, en, ev;
  logic [7:0] err;
  logic [4:0] bias;
  logic       lr, lk, fl;
  logic [2:0] st;
  int n_chk = 0;
  int n_pass = 0;
  adpll_acq_controller dut (
    .fpga_clk_i(clk), .reset_i(rst), .enable_i(en), .error_i(err), .error_valid_i(ev),
    .bias_o(bias), .loop_reset_o(lr), .locked_o(lk), .fail_o(fl), .state_o(st)
  );
  always #5 clk = ~clk;
  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  // One error strobe; called and returns on a falling edge, so outputs seen afterwards reflect this sample.
  task automatic smp(input int e);
    err = 8'(e);
    ev  = 1'b1;
    @(negedge clk);
    ev  = 1'b0;
  endtask
  // Plant whose error is positive up to bias 21 and negative above it.
  function automatic int plant();
    return 2 * (21 - int'(bias)) + 1;
  endfunction
  task automatic sweep();
    for (int i = 1; i <= 25; i++) begin
      smp(plant());
      if (i < 25) begin
        check("sweep_state", st, 1);
        check("sweep_lr", lr, 1);
      end
    end
    check("sweep_done_state", st, 2);
    check("sweep_bias", bias, 21);
    check("sweep_done_lr", lr, 0);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, st, 0);
    check({tag, "_bias"}, bias, 16);
    check({tag, "_lr"}, lr, 1);
    check({tag, "_locked"}, lk, 0);
    check({tag, "_fail"}, fl, 0);
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; ev = 1'b0; err = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", st, 0);
    en = 1'b1;
    @(negedge clk);
    check("enter_sweep", st, 1);
    check("sweep_first_bias", bias, 16);
    check("sweep_first_lr", lr, 1);
    sweep();
    for (int i = 1; i <= 16; i++) begin
      smp(i % 2 ? 1 : -2);
      if (i == 15) begin
        check("track15_locked", lk, 0);
        check("track15_state", st, 2);
      end
    end
    check("track16_locked", lk, 1);
    check("track16_state", st, 3);
    check("locked_lr", lr, 0);
    repeat (3) smp(9);
    smp(0);
    check("burst_plus9", lk, 1);
    repeat (6) smp(5);
    check("band_plus5", lk, 1);
    repeat (3) smp(-9);
    check("minus9_x3", lk, 1);
    smp(-9);
    check("minus9_x4_locked", lk, 0);
    check("minus9_x4_state", st, 1);
    check("minus9_x4_bias", bias, 16);
    check("minus9_x4_lr", lr, 1);
    sweep();
    for (int i = 1; i <= 26; i++) begin
      smp(i == 10 ? 3 : (i % 2 ? 1 : -2));
      if (i == 16) check("delay16_locked", lk, 0);
      if (i == 25) check("delay25_locked", lk, 0);
    end
    check("delay26_locked", lk, 1);
    repeat (3) smp(-128);
    check("neg_min_x3", lk, 1);
    smp(-128);
    check("neg_min_x4_state", st, 1);
    sweep();
    for (int i = 1; i <= 16; i++) smp(i % 2 ? 1 : -2);
    check("relock_state", st, 3);
    rst = 1'b1;
    err = 8'(-20);
    ev  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ev  = 1'b0;
    check_reset_vals("midreset");
    @(negedge clk);
    check("post_reset_sweep", st, 1);
    for (int r = 0; r < 4; r++) begin
      sweep();
      repeat (254) smp(50);
      check("timeout254_state", st, 2);
      smp(50);
      check("timeout_state", st, r < 3 ? 1 : 4);
    end
    check("fail_flag", fl, 1);
    check("fail_lr", lr, 1);
    check("fail_bias", bias, 21);
    smp(0);
    check("fail_sticky", st, 4);
    en = 1'b0;
    @(negedge clk);
    check_reset_vals("disable");
    en = 1'b1;
    @(negedge clk);
    check("reenable", st, 1);
    repeat (24) smp(plant());
    err = 8'(plant());
    ev  = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    ev  = 1'b0;
    check("race_state", st, 0);
    check("race_bias", bias, 16);
    @(negedge clk);
    check("race_hold", st, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
